// File: rtl/mc_ctrl_if.sv
// Control bundle between mc_ctrl_fsm (master) and the MulticycleRISC Datapath (slave).
interface mc_ctrl_if #(
    parameter int ALUOP_W = 2
);
    logic               start;
    logic [4:0]         opcode;
    logic [1:0]         ALUopcode;
    logic [2:0]         PSW_NZC;

    logic               Buff_PC;
    logic               Buff_MEMIns;
    logic               ALUorNot;
    logic               LIorMOV;
    logic               MEMresource;
    logic               WE_MEM;
    logic               WBresource;
    logic               RBresource;
    logic               oprandB;
    logic               LI;
    logic               PCplus1orWB;
    logic               WE_RF;
    logic               Branch;
    logic [1:0]         Jump;
    logic [ALUOP_W-1:0] ALUop;
    logic               Flag;
    logic               Buff_PSW;
    logic               done;
    logic               illegal;

    modport master (
        input  start, opcode, ALUopcode, PSW_NZC,
        output Buff_PC, Buff_MEMIns, ALUorNot, LIorMOV, MEMresource, WE_MEM,
               WBresource, RBresource, oprandB, LI, PCplus1orWB, WE_RF,
               Branch, Jump, ALUop, Flag, Buff_PSW, done, illegal
    );

    modport slave (
        output start, opcode, ALUopcode, PSW_NZC,
        input  Buff_PC, Buff_MEMIns, ALUorNot, LIorMOV, MEMresource, WE_MEM,
               WBresource, RBresource, oprandB, LI, PCplus1orWB, WE_RF,
               Branch, Jump, ALUop, Flag, Buff_PSW, done, illegal
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multicycle controller: FETCH/DECODE/EXEC/MEM/WB sequencing with memory wait states,
// halt/resume and illegal-opcode handling. MC_CTRL_PERF_CNT_EN adds cyc_cnt/ret_cnt.
module mc_ctrl_fsm #(
    parameter int ALUOP_W         = 2,
    parameter int MEM_WAIT        = 0,
    parameter int HALT_ON_ILLEGAL = 0,
    parameter int CNT_W           = 16
) (
    input  logic           clk,
    input  logic           Rst,
    mc_ctrl_if.master      bus
`ifdef MC_CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt
`endif
);

    localparam logic [4:0] OP_ALU   = 5'b00000;
    localparam logic [4:0] OP_LLI   = 5'b00001;
    localparam logic [4:0] OP_LHI   = 5'b00010;
    localparam logic [4:0] OP_LDRRI = 5'b00011;
    localparam logic [4:0] OP_LDRRR = 5'b00100;
    localparam logic [4:0] OP_STRRI = 5'b00101;
    localparam logic [4:0] OP_STRRR = 5'b00110;
    localparam logic [4:0] OP_OUTR  = 5'b00111;
    localparam logic [4:0] OP_BZ    = 5'b01000;
    localparam logic [4:0] OP_JMP   = 5'b01001;
    localparam logic [4:0] OP_JR    = 5'b01010;
    localparam logic [4:0] OP_BC    = 5'b01011;
    localparam logic [4:0] OP_HLT   = 5'b11111;

    localparam logic [3:0] WAIT_MAX    = 4'(MEM_WAIT);
    localparam logic       FIRST_LAST  = (MEM_WAIT == 0);
    localparam logic       ILL_IS_NOP  = (HALT_ON_ILLEGAL == 0);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT
    } state_t;

    typedef struct packed {
        logic       buff_pc;
        logic       buff_memins;
        logic       aluornot;
        logic       liormov;
        logic       memresource;
        logic       we_mem;
        logic       wbresource;
        logic       rbresource;
        logic       oprandb;
        logic       li;
        logic       pcplus1orwb;
        logic       we_rf;
        logic       br_z;
        logic       br_c;
        logic [1:0] jump;
        logic       aluop;
        logic       flag;
        logic       buff_psw;
        logic       done;
    } ctl_t;

    state_t     state;
    logic [3:0] wcnt;
    logic [4:0] op_r;
    logic [1:0] fn_r;
    logic       illegal;
    ctl_t       ctl;

    function automatic logic op_legal(input logic [4:0] op);
        return (op <= OP_BC) || (op == OP_HLT);
    endfunction

    function automatic logic is_str(input logic [4:0] op);
        return (op == OP_STRRI) || (op == OP_STRRR);
    endfunction

    function automatic logic is_flow(input logic [4:0] op);
        return (op == OP_BZ) || (op == OP_BC) || (op == OP_JMP) || (op == OP_JR);
    endfunction

    // Control word presented while sitting in state s for op; last marks the final wait cycle.
    function automatic ctl_t ctl_for(input state_t s, input logic [4:0] op,
                                     input logic [1:0] fn, input logic last);
        ctl_t c;
        c = '0;
        case (s)
            FETCH: c.buff_memins = last;
            DECODE: begin
                c.rbresource = (op == OP_LHI);
                c.li         = (op == OP_LHI);
                c.oprandb    = (op == OP_LDRRI) || (op == OP_STRRI);
                c.buff_pc    = (op == OP_OUTR) || (op == OP_HLT) || (!op_legal(op) && ILL_IS_NOP);
            end
            EXEC: begin
                case (op)
                    OP_ALU: begin
                        c.buff_psw = 1'b1;
                        c.flag     = fn[0];
                        c.aluop    = fn[1];
                    end
                    OP_STRRI, OP_STRRR: c.rbresource = 1'b1;
                    OP_BZ:  begin c.br_z = 1'b1; c.buff_pc = 1'b1; end
                    OP_BC:  begin c.br_c = 1'b1; c.buff_pc = 1'b1; end
                    OP_JMP: begin c.jump = 2'b01; c.buff_pc = 1'b1; end
                    OP_JR:  begin c.jump = 2'b10; c.buff_pc = 1'b1; end
                    default: ;
                endcase
            end
            MEM: begin
                case (op)
                    OP_LLI, OP_LHI:     c.aluornot    = 1'b1;
                    OP_LDRRI, OP_LDRRR: c.memresource = 1'b1;
                    OP_STRRI, OP_STRRR: begin
                        c.memresource = 1'b1;
                        c.we_mem      = last;
                        c.buff_pc     = last;
                    end
                    default: ;
                endcase
            end
            WB: begin
                c.we_rf       = 1'b1;
                c.pcplus1orwb = 1'b1;
                c.buff_pc     = 1'b1;
                c.wbresource  = (op == OP_LDRRI) || (op == OP_LDRRR);
            end
            HALT:    c.done = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state   <= IDLE;
            wcnt    <= '0;
            op_r    <= '0;
            fn_r    <= '0;
            illegal <= 1'b0;
            ctl     <= '0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (bus.start) begin
                        state <= FETCH;
                        wcnt  <= '0;
                        ctl   <= ctl_for(FETCH, op_r, fn_r, FIRST_LAST);
                    end
                end
                FETCH: begin
                    if (wcnt == WAIT_MAX) begin
                        state   <= DECODE;
                        wcnt    <= '0;
                        op_r    <= bus.opcode;
                        fn_r    <= bus.ALUopcode;
                        illegal <= illegal | ~op_legal(bus.opcode);
                        ctl     <= ctl_for(DECODE, bus.opcode, bus.ALUopcode, 1'b0);
                    end else begin
                        wcnt <= wcnt + 4'd1;
                        ctl  <= ctl_for(FETCH, op_r, fn_r, (wcnt + 4'd1) == WAIT_MAX);
                    end
                end
                DECODE: begin
                    if (op_r == OP_OUTR || (!op_legal(op_r) && ILL_IS_NOP)) begin
                        state <= FETCH;
                        wcnt  <= '0;
                        ctl   <= ctl_for(FETCH, op_r, fn_r, FIRST_LAST);
                    end else if (op_r == OP_HLT || !op_legal(op_r)) begin
                        state <= HALT;
                        ctl   <= ctl_for(HALT, op_r, fn_r, 1'b0);
                    end else begin
                        state <= EXEC;
                        ctl   <= ctl_for(EXEC, op_r, fn_r, 1'b0);
                    end
                end
                EXEC: begin
                    wcnt <= '0;
                    if (is_flow(op_r)) begin
                        state <= FETCH;
                        ctl   <= ctl_for(FETCH, op_r, fn_r, FIRST_LAST);
                    end else begin
                        state <= MEM;
                        ctl   <= ctl_for(MEM, op_r, fn_r, FIRST_LAST);
                    end
                end
                MEM: begin
                    if (wcnt == WAIT_MAX) begin
                        wcnt <= '0;
                        if (is_str(op_r)) begin
                            state <= FETCH;
                            ctl   <= ctl_for(FETCH, op_r, fn_r, FIRST_LAST);
                        end else begin
                            state <= WB;
                            ctl   <= ctl_for(WB, op_r, fn_r, 1'b0);
                        end
                    end else begin
                        wcnt <= wcnt + 4'd1;
                        ctl  <= ctl_for(MEM, op_r, fn_r, (wcnt + 4'd1) == WAIT_MAX);
                    end
                end
                WB: begin
                    state <= FETCH;
                    wcnt  <= '0;
                    ctl   <= ctl_for(FETCH, op_r, fn_r, FIRST_LAST);
                end
                default: begin
                    state <= IDLE;
                    ctl   <= '0;
                end
            endcase
        end
    end

    // Branch is the only output that looks at live flags: it uses PSW as seen during EXEC.
    assign bus.Branch      = (ctl.br_z & bus.PSW_NZC[1]) | (ctl.br_c & bus.PSW_NZC[0]);
    assign bus.Buff_PC     = ctl.buff_pc;
    assign bus.Buff_MEMIns = ctl.buff_memins;
    assign bus.ALUorNot    = ctl.aluornot;
    assign bus.LIorMOV     = ctl.liormov;
    assign bus.MEMresource = ctl.memresource;
    assign bus.WE_MEM      = ctl.we_mem;
    assign bus.WBresource  = ctl.wbresource;
    assign bus.RBresource  = ctl.rbresource;
    assign bus.oprandB     = ctl.oprandb;
    assign bus.LI          = ctl.li;
    assign bus.PCplus1orWB = ctl.pcplus1orwb;
    assign bus.WE_RF       = ctl.we_rf;
    assign bus.Jump        = ctl.jump;
    assign bus.ALUop       = ALUOP_W'(ctl.aluop);
    assign bus.Flag        = ctl.flag;
    assign bus.Buff_PSW    = ctl.buff_psw;
    assign bus.done        = ctl.done;
    assign bus.illegal     = illegal;

    logic unused_psw_n;
    assign unused_psw_n = bus.PSW_NZC[2];

`ifdef MC_CTRL_PERF_CNT_EN
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            if (state != IDLE && state != HALT)
                cyc_cnt <= cyc_cnt + CNT_W'(1);
            if (ctl.buff_pc)
                ret_cnt <= ret_cnt + CNT_W'(1);
        end
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized bench for mc_ctrl_fsm: two instances (no-wait/NOP-on-illegal and
// 3-wait/halt-on-illegal) checked cycle by cycle against an instruction-level model.
module tb_mc_ctrl_fsm;

    typedef struct packed {
        logic       buff_pc;
        logic       buff_memins;
        logic       aluornot;
        logic       liormov;
        logic       memresource;
        logic       we_mem;
        logic       wbresource;
        logic       rbresource;
        logic       oprandb;
        logic       li;
        logic       pcplus1orwb;
        logic       we_rf;
        logic       branch;
        logic [1:0] jump;
        logic [1:0] aluop;
        logic       flag;
        logic       buff_psw;
        logic       done;
        logic       illegal;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [4:0] opcode = '0;
    logic [1:0] aluopc = '0;
    logic [2:0] psw = '0;
    int         sel = 0;

    int vectors = 0;
    int miscompares = 0;
    int ncyc, nfetch, first_done;
    bit ill_m [2];
    vec_t expq[$];

    always #5 clk = ~clk;

    mc_ctrl_if #(.ALUOP_W(2)) ifa ();
    mc_ctrl_if #(.ALUOP_W(2)) ifb ();

    assign ifa.start = start && (sel == 0);
    assign ifb.start = start && (sel == 1);
    assign ifa.opcode = opcode;
    assign ifb.opcode = opcode;
    assign ifa.ALUopcode = aluopc;
    assign ifb.ALUopcode = aluopc;
    assign ifa.PSW_NZC = psw;
    assign ifb.PSW_NZC = psw;

`ifdef MC_CTRL_PERF_CNT_EN
    logic [3:0]  cyc_a, ret_a;
    logic [15:0] unused_cyc_b, unused_ret_b;
`endif

    mc_ctrl_fsm #(.ALUOP_W(2), .MEM_WAIT(0), .HALT_ON_ILLEGAL(0), .CNT_W(4)) dut_a (
        .clk(clk), .Rst(rst), .bus(ifa)
`ifdef MC_CTRL_PERF_CNT_EN
        , .cyc_cnt(cyc_a), .ret_cnt(ret_a)
`endif
    );

    mc_ctrl_fsm #(.ALUOP_W(2), .MEM_WAIT(3), .HALT_ON_ILLEGAL(1), .CNT_W(16)) dut_b (
        .clk(clk), .Rst(rst), .bus(ifb)
`ifdef MC_CTRL_PERF_CNT_EN
        , .cyc_cnt(unused_cyc_b), .ret_cnt(unused_ret_b)
`endif
    );

    vec_t obs_a, obs_b, obs;
    assign obs_a = {ifa.Buff_PC, ifa.Buff_MEMIns, ifa.ALUorNot, ifa.LIorMOV, ifa.MEMresource,
                    ifa.WE_MEM, ifa.WBresource, ifa.RBresource, ifa.oprandB, ifa.LI,
                    ifa.PCplus1orWB, ifa.WE_RF, ifa.Branch, ifa.Jump, ifa.ALUop, ifa.Flag,
                    ifa.Buff_PSW, ifa.done, ifa.illegal};
    assign obs_b = {ifb.Buff_PC, ifb.Buff_MEMIns, ifb.ALUorNot, ifb.LIorMOV, ifb.MEMresource,
                    ifb.WE_MEM, ifb.WBresource, ifb.RBresource, ifb.oprandB, ifb.LI,
                    ifb.PCplus1orWB, ifb.WE_RF, ifb.Branch, ifb.Jump, ifb.ALUop, ifb.Flag,
                    ifb.Buff_PSW, ifb.done, ifb.illegal};
    assign obs = (sel == 1) ? obs_b : obs_a;

    // Expected per-cycle controls for one instruction, straight from the opcode table.
    task automatic build(input logic [4:0] op, input logic [1:0] fn, input logic [2:0] p);
        vec_t v;
        int  mw    = (sel == 1) ? 3 : 0;
        bit  hoi   = (sel == 1);
        bit  legal = (op <= 5'd11) || (op == 5'd31);
        bit  ldr   = (op == 5'd3) || (op == 5'd4);
        bit  str   = (op == 5'd5) || (op == 5'd6);
        expq.delete();
        for (int i = 0; i <= mw; i++) begin
            v = '0; v.illegal = ill_m[sel]; v.buff_memins = (i == mw);
            expq.push_back(v);
        end
        if (!legal) ill_m[sel] = 1'b1;
        v = '0; v.illegal = ill_m[sel];
        v.rbresource = (op == 5'd2);
        v.li = (op == 5'd2);
        v.oprandb = (op == 5'd3) || (op == 5'd5);
        v.buff_pc = (op == 5'd7) || (op == 5'd31) || (!legal && !hoi);
        expq.push_back(v);
        if (op == 5'd7 || (!legal && !hoi)) return;
        if (op == 5'd31 || !legal) begin
            v = '0; v.illegal = ill_m[sel]; v.done = 1'b1;
            expq.push_back(v);
            return;
        end
        v = '0; v.illegal = ill_m[sel];
        case (op)
            5'd0: begin v.buff_psw = 1'b1; v.flag = fn[0]; v.aluop = {1'b0, fn[1]}; end
            5'd8: begin v.branch = p[1]; v.buff_pc = 1'b1; end
            5'd11: begin v.branch = p[0]; v.buff_pc = 1'b1; end
            5'd9: begin v.jump = 2'b01; v.buff_pc = 1'b1; end
            5'd10: begin v.jump = 2'b10; v.buff_pc = 1'b1; end
            default: v.rbresource = str;
        endcase
        expq.push_back(v);
        if (op >= 5'd8) return;
        for (int i = 0; i <= mw; i++) begin
            v = '0; v.illegal = ill_m[sel];
            v.aluornot = (op == 5'd1) || (op == 5'd2);
            v.memresource = ldr || str;
            v.we_mem = str && (i == mw);
            v.buff_pc = str && (i == mw);
            expq.push_back(v);
        end
        if (str) return;
        v = '0; v.illegal = ill_m[sel];
        v.we_rf = 1'b1; v.pcplus1orwb = 1'b1; v.buff_pc = 1'b1; v.wbresource = ldr;
        expq.push_back(v);
    endtask

    task automatic do_instr(input logic [4:0] op, input logic [1:0] fn, input logic [2:0] p);
        opcode = op; aluopc = fn; psw = p;
        build(op, fn, p);
        for (int i = 0; i < expq.size(); i++) begin
            @(posedge clk); #1;
            ncyc++;
            if (obs.buff_memins) nfetch++;
            if (obs.done && first_done < 0) first_done = ncyc;
            vectors++;
            if (obs !== expq[i]) begin
                miscompares++;
                $display("FAIL ctrl_vec dut%0d op=%b step %0d: got %h, expected %h",
                         sel, op, i, obs, expq[i]);
            end
            // start is noise mid-instruction; after a halt it resumes the next one
            start = (i == expq.size() - 1) ? expq[i].done : 1'($urandom_range(0, 1));
        end
    endtask

    task automatic reset_all();
        rst = 1'b1; start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        ill_m[0] = 1'b0; ill_m[1] = 1'b0;
        ncyc = 0; nfetch = 0; first_done = -1;
    endtask

    task automatic test_reset();
        vec_t v;
        #12;
        vectors += 2;
        if (obs_a !== '0) begin miscompares++; $display("FAIL reset_a: got %h, expected 0", obs_a); end
        if (obs_b !== '0) begin miscompares++; $display("FAIL reset_b: got %h, expected 0", obs_b); end
        @(posedge clk); #1;
        rst = 1'b0; sel = 0; opcode = 5'd0; aluopc = 2'b00; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++;
        if (obs_a.buff_psw !== 1'b1) begin
            miscompares++; $display("FAIL add_exec_psw: got %b, expected 1", obs_a.buff_psw);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (obs_a !== '0) begin miscompares++; $display("FAIL reset_mid_exec: got %h, expected 0", obs_a); end
        #1 rst = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        v = '0; v.buff_memins = 1'b1;
        vectors++;
        if (obs_a !== v) begin miscompares++; $display("FAIL restart_fetch: got %h, expected %h", obs_a, v); end
    endtask

    task automatic test_program();
        logic [4:0] ops [8] = '{5'd1, 5'd2, 5'd1, 5'd0, 5'd7, 5'd0, 5'd7, 5'd31};
        logic [1:0] fns [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
        reset_all(); sel = 0; start = 1'b1;
        for (int i = 0; i < 8; i++) do_instr(ops[i], fns[i], 3'($urandom_range(0, 7)));
        start = 1'b0;
        vectors += 2;
        if (nfetch !== 8) begin miscompares++; $display("FAIL prog_fetches: got %0d, expected 8", nfetch); end
        if (first_done !== 32) begin miscompares++; $display("FAIL prog_done_cycle: got %0d, expected 32", first_done); end
    endtask

    task automatic test_str_wait();
        reset_all(); sel = 1; start = 1'b1;
        do_instr(5'd5, 2'b00, 3'b000);
        do_instr(5'd4, 2'b00, 3'b000);
        do_instr(5'd0, 2'b11, 3'b000);
        vectors++;
        if (ncyc !== 10 + 11 + 11) begin miscompares++; $display("FAIL wait_cycles: got %0d, expected 32", ncyc); end
    endtask

    task automatic test_branch();
        reset_all(); sel = 0; start = 1'b1;
        do_instr(5'd8, 2'b00, 3'b010);
        do_instr(5'd8, 2'b00, 3'b000);
        do_instr(5'd11, 2'b00, 3'b001);
        do_instr(5'd11, 2'b00, 3'b110);
        do_instr(5'd9, 2'b00, 3'b000);
        do_instr(5'd10, 2'b00, 3'b000);
    endtask

    task automatic test_illegal();
        reset_all(); sel = 0; start = 1'b1;
        do_instr(5'b10101, 2'b00, 3'b000);
        do_instr(5'd0, 2'b10, 3'b000);
        reset_all(); sel = 1; start = 1'b1;
        do_instr(5'b10101, 2'b00, 3'b000);
        do_instr(5'd1, 2'b00, 3'b000);
    endtask

    task automatic test_random();
        int r;
        for (int s = 0; s < 2; s++) begin
            reset_all(); sel = s; start = 1'b1;
            for (int n = 0; n < 30; n++) begin
                r = $urandom_range(0, 14);
                if (r <= 11) opcode = 5'(r);
                else if (r == 12) opcode = 5'd31;
                else opcode = 5'($urandom_range(12, 30));
                do_instr(opcode, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
            end
        end
    endtask

`ifdef MC_CTRL_PERF_CNT_EN
    task automatic test_perf();
        reset_all(); sel = 0; start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            do_instr(5'd7, 2'b00, 3'b000);
            vectors += 2;
            if (ret_a !== 4'((k - 1) % 16)) begin
                miscompares++; $display("FAIL ret_cnt k=%0d: got %0d, expected %0d", k, ret_a, (k - 1) % 16);
            end
            if (cyc_a !== 4'((2 * k - 1) % 16)) begin
                miscompares++; $display("FAIL cyc_cnt k=%0d: got %0d, expected %0d", k, cyc_a, (2 * k - 1) % 16);
            end
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (cyc_a !== 4'd0 || ret_a !== 4'd0) begin
            miscompares++; $display("FAIL cnt_reset: got %0d/%0d, expected 0/0", cyc_a, ret_a);
        end
        reset_all();
    endtask
`endif

    initial begin
        test_reset();
        test_program();
        test_str_wait();
        test_branch();
        test_illegal();
        test_random();
`ifdef MC_CTRL_PERF_CNT_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
